power_arbiter: RTL

//  Shares one power_n-style exponent engine among NREQ requesters using round-robin

---
 rtl/power_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/power_arbiter.sv
// power_arbiter
//   Round-robin front end for a single shared exponent engine. One of NREQ
//   requesters is chosen while idle; its base/exponent operands are latched
//   and presented to the engine, the engine is started with a one-cycle
//   pulse, and the arbiter waits for eng_done or a timeout. The outcome is
//   returned on a one-cycle per-requester strobe.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low
//   req          : level request per requester, held until its rsp_valid
//   req_base     : packed base operands, slice i belongs to requester i
//   req_exp      : packed exponent operands, slice i belongs to requester i
//   gnt          : one-hot grant, high from GRANT through WAIT
//   rsp_valid    : one-cycle response strobe per requester
//   rsp_data     : result, meaningful only while rsp_valid is non-zero
//   rsp_err      : timeout flag, qualified by rsp_valid
//   busy         : high in every state except IDLE
//   eng_start    : one-cycle engine start pulse
//   eng_base     : latched base operand for the engine
//   eng_exponent : latched exponent operand for the engine
//   eng_result   : engine result, valid with eng_done
//   eng_done     : one-cycle engine completion strobe

module power_arbiter #(
    parameter int NREQ    = 4,
    parameter int BW      = 3,
    parameter int EW      = 3,
    parameter int PW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*BW-1:0]   req_base,
    input  logic [NREQ*EW-1:0]   req_exp,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [PW-1:0]        rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 eng_start,
    output logic [BW-1:0]        eng_base,
    output logic [EW-1:0]        eng_exponent,
    input  logic [PW-1:0]        eng_result,
    input  logic                 eng_done
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   idx_q;
    logic [BW-1:0]   base_q;
    logic [EW-1:0]   exp_q;
    logic [TW-1:0]   timer_q;
    logic [PW-1:0]   data_q;
    logic            err_q;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   slot;
    logic            timer_last;

    // Requester index at distance k (1..NREQ) past the pointer, wrapping at NREQ
    // so non-power-of-two requester counts never address an absent slot.
    function automatic logic [IW-1:0] rr_slot(input logic [IW-1:0] p, input int unsigned k);
        int unsigned s;
        s = {{(32-IW){1'b0}}, p} + k;
        if (s >= int'(NREQ))
            s = s - int'(NREQ);
        return IW'(s);
    endfunction

    // Round-robin pick: first set request scanning ptr+1, ptr+2, ...
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        slot       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            slot = rr_slot(ptr_q, k);
            if (!pick_found && req[slot]) begin
                pick_found = 1'b1;
                pick_idx   = slot;
            end
        end
    end

    assign timer_last = (timer_q == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pick_found) state_nxt = S_GRANT;
            S_GRANT:  state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT:   if (eng_done || timer_last) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Transaction datapath: operands, timer, result and the round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= IW'(NREQ - 1);
            idx_q   <= '0;
            base_q  <= '0;
            exp_q   <= '0;
            timer_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        idx_q  <= pick_idx;
                        base_q <= req_base[pick_idx*BW +: BW];
                        exp_q  <= req_exp[pick_idx*EW +: EW];
                    end
                end
                S_LAUNCH: timer_q <= '0;
                S_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    // done takes precedence over a simultaneous timeout
                    if (eng_done) begin
                        data_q <= eng_result;
                        err_q  <= 1'b0;
                    end else if (timer_last) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                S_RESP: ptr_q <= idx_q;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        gnt          = '0;
        rsp_valid    = '0;
        rsp_data     = '0;
        rsp_err      = 1'b0;
        eng_start    = 1'b0;
        busy         = (state != S_IDLE);
        eng_base     = base_q;
        eng_exponent = exp_q;
        case (state)
            S_GRANT, S_WAIT: gnt[idx_q] = 1'b1;
            S_LAUNCH: begin
                gnt[idx_q] = 1'b1;
                eng_start  = 1'b1;
            end
            S_RESP: begin
                rsp_valid[idx_q] = 1'b1;
                rsp_data         = data_q;
                rsp_err          = err_q;
            end
            default: ;
        endcase
    end

endmodule
